key_mode_ctrl: RTL and testbench

Upstream control stage for the PL LED path: samples the board push-button on `sys_clk`, synchronises and debounces it, and emits clean one-cycle press and release events. It also keeps a wrapping display-mode index. The LED pattern block consumes the index to select its pattern. The block runs entirely in the `sys_clk` domain beside the PS block and has no AXI or PS connection.

---
 rtl/key_pkg.sv | 19 +
 rtl/sync_2ff.sv | 28 ++
 rtl/key_mode_ctrl.sv | 162 ++++++++++++++++
 tb/tb_key_mode_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button / display-mode control path.
package key_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_PRESS_FILT,
    KEY_HELD,
    KEY_REL_FILT
  } key_state_e;

  function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous PL inputs; reset value is a parameter.
module sync_2ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both stages sample the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Push-button synchroniser + debouncer emitting press/release pulses and a wrapping mode index.
// Optional long-press event (forces mode to 0) is built only when KEY_LONG_PRESS_EN is defined.
module key_mode_ctrl
  import key_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned MODE_NUM    = 4
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        key_n,
  output logic                        key_press,
  output logic                        key_release,
  output logic                        key_long,
  output logic [$clog2(MODE_NUM)-1:0] mode
);

  localparam int unsigned DB_CYC   = ms_to_cyc(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYC = ms_to_cyc(CLK_FREQ_HZ, LONG_MS);
  localparam int unsigned CNT_W    = $clog2(max_u(DB_CYC, LONG_CYC) + 1);
  localparam int unsigned MODE_W   = $clog2(MODE_NUM);

  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);

  logic key_s;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_key_sync (
    .clk  (sys_clk),
    .rst_n(rst_n),
    .d    (key_n),
    .q    (key_s)
  );

  key_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [MODE_W-1:0] mode_q, mode_d, mode_inc;
  logic              press_q, press_d;
  logic              release_q, release_d;

  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign mode_inc = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      KEY_IDLE: begin
        if (!key_s) begin
          state_d = KEY_PRESS_FILT;
          cnt_d   = '0;
        end
      end
      KEY_PRESS_FILT: begin
        if (key_s) begin
          state_d = KEY_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = KEY_HELD;
          press_d = 1'b1;
          mode_d  = mode_inc;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      KEY_HELD: begin
        if (key_s) begin
          state_d = KEY_REL_FILT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      KEY_REL_FILT: begin
        if (!key_s) begin
          // Bounce back to pressed: the press is still in progress, keep counting.
          state_d = KEY_HELD;
          cnt_d   = cnt_inc;
        end else if (cnt_q == DB_LAST) begin
          state_d   = KEY_IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = KEY_IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef KEY_LONG_PRESS_EN
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if (((state_q == KEY_HELD) || (state_q == KEY_REL_FILT)) &&
                 (hold_q < HOLD_W'(LONG_CYC))) begin
      // Saturating at LONG_CYC guarantees a single long pulse per press.
      hold_d = hold_q + HOLD_W'(1);
      if ((hold_q == HOLD_W'(LONG_CYC - 1)) && (state_d != KEY_IDLE)) begin
        long_d = 1'b1;
        mode_d = '0;
      end
    end
`endif
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= KEY_IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
      hold_q    <= '0;
      long_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef KEY_LONG_PRESS_EN
      hold_q    <= hold_d;
      long_q    <= long_d;
`endif
    end
  end

  assign key_press   = press_q;
  assign key_release = release_q;
  assign mode        = mode_q;

`ifdef KEY_LONG_PRESS_EN
  assign key_long = long_q;
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Scoreboard bench for key_mode_ctrl: directed key waveforms push expected events, a monitor checks them.
module tb_key_mode_ctrl;

  localparam int MODE_NUM = 4;
  localparam int LAT      = 7;   // DB_CYC + 2
  localparam int LONG_CYC = 20;

  localparam int EV_PRESS = 1;
  localparam int EV_REL   = 2;
  localparam int EV_LONG  = 3;

  typedef struct {
    int kind;
    int cyc;
    int mode;
  } exp_t;

  logic       sys_clk;
  logic       rst_n;
  logic       key_n;
  logic       key_press;
  logic       key_release;
  logic       key_long;
  logic [1:0] mode;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   exp_mode = 0;
  int   t_drive = 0;
  exp_t exp_q[$];

  key_mode_ctrl #(
    .CLK_FREQ_HZ(1000),
    .DEBOUNCE_MS(5),
    .LONG_MS    (20),
    .MODE_NUM   (MODE_NUM)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .mode       (mode)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #100_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int got, input int expv);
    n_vec++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input int at_cyc, input int m);
    exp_t e;
    e.kind = kind;
    e.cyc  = at_cyc;
    e.mode = m;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Holds key_n at v for exactly `n` sampling edges; t_drive is the first of them.
  task automatic drive_key(input logic v, input int n);
    @(negedge sys_clk);
    key_n   = v;
    t_drive = cyc + 1;
    wait_cyc(n - 1);
  endtask

  task automatic press_release(input int hold, input bit long_exp);
    drive_key(1'b0, 1);
    exp_mode = (exp_mode + 1) % MODE_NUM;
    push(EV_PRESS, t_drive + LAT, exp_mode);
    if (long_exp) begin
      exp_mode = 0;
      push(EV_LONG, t_drive + LAT + LONG_CYC, 0);
    end
    wait_cyc(hold - 1);
    drive_key(1'b1, 1);
    push(EV_REL, t_drive + LAT, exp_mode);
    wait_cyc(12);
    check("idle_mode", int'(mode), exp_mode);
  endtask

  // Monitor: every pulse pops one expected event and is compared on kind, cycle and mode.
  always @(negedge sys_clk) begin
    int   kind;
    exp_t e;
    if (key_press || key_release || key_long) begin
      kind = key_press ? EV_PRESS : (key_release ? EV_REL : EV_LONG);
      check("pulse_onehot", $countones({key_press, key_release, key_long}), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_event", kind, 0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        check("event_cycle", cyc, e.cyc);
        check("event_mode", int'(mode), e.mode);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    key_n = 1'b1;
    wait_cyc(3);
    check("rst_press", int'(key_press), 0);
    check("rst_release", int'(key_release), 0);
    check("rst_long", int'(key_long), 0);
    check("rst_mode", int'(mode), 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    wait_cyc(3);

    // Five clean presses: mode 1, 2, 3, 0, 1.
    for (int i = 0; i < 5; i++) press_release(10, 1'b0);

    // Three 2-cycle bounces, then a stable low.
    for (int b = 0; b < 3; b++) begin
      drive_key(1'b0, 2);
      drive_key(1'b1, 2);
    end
    press_release(10, 1'b0);

    // 4-cycle glitch is rejected.
    drive_key(1'b0, 4);
    drive_key(1'b1, 1);
    wait_cyc(12);
    check("glitch_mode", int'(mode), exp_mode);

    // 40-cycle hold starting at mode 2.
`ifdef KEY_LONG_PRESS_EN
    press_release(40, 1'b1);
`else
    press_release(40, 1'b0);
`endif

    // Reset during PRESS_FILT with the key kept low.
    drive_key(1'b0, 1);
    wait_cyc(3);
    @(negedge sys_clk);
    rst_n = 1'b0;
    wait_cyc(2);
    exp_mode = 0;
    check("midrst_press", int'(key_press), 0);
    check("midrst_release", int'(key_release), 0);
    check("midrst_long", int'(key_long), 0);
    check("midrst_mode", int'(mode), 0);
    @(negedge sys_clk);
    rst_n    = 1'b1;
    exp_mode = 1;
    push(EV_PRESS, cyc + 1 + LAT, exp_mode);
    wait_cyc(11);
    drive_key(1'b1, 1);
    push(EV_REL, t_drive + LAT, exp_mode);
    wait_cyc(12);
    check("final_mode", int'(mode), exp_mode);

    check("events_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
